// File: rtl/pit_seq_pkg.sv
// Shared encodings for the 8254 command sequencer: command opcodes, the control
// port address, the sequencer state type and control-word builders.
package pit_seq_pkg;

    localparam logic [1:0] OP_PROGRAM = 2'b00;
    localparam logic [1:0] OP_LATCH   = 2'b01;
    localparam logic [1:0] OP_STATUS  = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    localparam logic [1:0] A_CTRL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CW   = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_RESP = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    function automatic logic [7:0] program_cw(input logic [1:0] sel, input logic [1:0] rw,
                                              input logic [2:0] mode, input logic bcd);
        return {sel, rw, mode, bcd};
    endfunction

    function automatic logic [7:0] latch_cw(input logic [1:0] sel);
        return {sel, 6'b00_0000};
    endfunction

    // Read-back: COUNT_n=1 (no count latch), STATUS_n=0, one counter-select bit set.
    function automatic logic [7:0] readback_cw(input logic [1:0] sel);
        return 8'hE0 | (8'h02 << sel);
    endfunction

    function automatic logic cmd_error(input logic [1:0] op, input logic [1:0] sel,
                                       input logic [1:0] rw, input logic [1:0] shadow_rw);
        return (sel == 2'd3) || (op == OP_RSVD) ||
               ((op == OP_PROGRAM) && (rw == 2'b00)) ||
               ((op == OP_LATCH) && (shadow_rw == 2'b00));
    endfunction

endpackage

// File: rtl/pit_bus_cycle.sv
// Executes one read or write byte cycle on the timer CPU port: SETUP, STROBE,
// HOLD, then a single GAP cycle during which the next byte may be launched.
module pit_bus_cycle #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       is_read,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic       gap,
    output logic [7:0] rdata,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [1:0] a,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in
);

    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_SETUP  = 3'd1;
    localparam logic [2:0] PH_STROBE = 3'd2;
    localparam logic [2:0] PH_HOLD   = 3'd3;
    localparam logic [2:0] PH_GAP    = 3'd4;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);

    logic [2:0] phase_q, phase_d;
    logic [3:0] cnt_q, cnt_d;
    logic       is_read_q, is_read_d;
    logic [7:0] rdata_q, rdata_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic [1:0] a_q, a_d;
    logic [7:0] d_out_q, d_out_d;
    logic       d_oe_q, d_oe_d;

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        is_read_d = is_read_q;
        rdata_d   = rdata_q;
        cs_n_d    = cs_n_q;
        rd_n_d    = rd_n_q;
        wr_n_d    = wr_n_q;
        a_d       = a_q;
        d_out_d   = d_out_q;
        d_oe_d    = d_oe_q;
        case (phase_q)
            PH_IDLE, PH_GAP: begin
                if (start) begin
                    phase_d   = PH_SETUP;
                    cnt_d     = 4'd0;
                    is_read_d = is_read;
                    cs_n_d    = 1'b0;
                    a_d       = addr;
                    d_out_d   = is_read ? 8'h00 : wdata;
                    d_oe_d    = ~is_read;
                end else begin
                    phase_d = PH_IDLE;
                end
            end
            PH_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    phase_d = PH_STROBE;
                    cnt_d   = 4'd0;
                    rd_n_d  = ~is_read_q;
                    wr_n_d  = is_read_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PH_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    phase_d = PH_HOLD;
                    cnt_d   = 4'd0;
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    // Read data is taken on the edge that closes the strobe.
                    if (is_read_q) begin
                        rdata_d = d_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PH_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    phase_d = PH_GAP;
                    cnt_d   = 4'd0;
                    cs_n_d  = 1'b1;
                    d_oe_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_IDLE;
            cnt_q     <= 4'd0;
            is_read_q <= 1'b0;
            rdata_q   <= 8'h00;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            a_q       <= 2'b00;
            d_out_q   <= 8'h00;
            d_oe_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            is_read_q <= is_read_d;
            rdata_q   <= rdata_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            a_q       <= a_d;
            d_out_q   <= d_out_d;
            d_oe_q    <= d_oe_d;
        end
    end

    assign done  = (phase_q == PH_HOLD) && (cnt_q == HOLD_LAST);
    assign gap   = (phase_q == PH_GAP);
    assign rdata = rdata_q;
    assign cs_n  = cs_n_q;
    assign rd_n  = rd_n_q;
    assign wr_n  = wr_n_q;
    assign a     = a_q;
    assign d_out = d_out_q;
    assign d_oe  = d_oe_q;

endmodule

// File: rtl/pit_sequencer.sv
// Command-driven bus master for an 8254 timer: turns program / latch-read /
// status read-back commands into control-word and data byte cycles.
module pit_sequencer
    import pit_seq_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_sel,
    input  logic [1:0]  cmd_rw,
    input  logic [2:0]  cmd_mode,
    input  logic        cmd_bcd,
    input  logic [15:0] cmd_count,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic        cs_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic [1:0]  a,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in
);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  fmt_q, fmt_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  lsb_q, lsb_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [1:0]  shadow_q [3];
    logic        shadow_we;

    logic        accept;
    logic [1:0]  cmd_shadow;
    logic        cmd_err;
    logic        last_byte;
    logic        bus_start;
    logic        bus_is_read;
    logic [1:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_done;
    logic        bus_gap;
    logic [7:0]  bus_rdata;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready && !rst;

    always_comb begin
        case (cmd_sel)
            2'd0:    cmd_shadow = shadow_q[0];
            2'd1:    cmd_shadow = shadow_q[1];
            2'd2:    cmd_shadow = shadow_q[2];
            default: cmd_shadow = 2'b00;
        endcase
    end

    assign cmd_err   = cmd_error(cmd_op, cmd_sel, cmd_rw, cmd_shadow);
    assign last_byte = (state_q == ST_HI) || ((state_q == ST_LO) && !fmt_q[1]);

    // fmt_q holds which data bytes follow the control word: the RW field for
    // program, the shadowed RW for latch-read, and LSB-only for status.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sel_d       = sel_q;
        fmt_d       = fmt_q;
        count_d     = count_q;
        lsb_d       = lsb_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = 16'h0000;
        shadow_we   = 1'b0;
        bus_start   = 1'b0;
        bus_is_read = 1'b0;
        bus_addr    = A_CTRL;
        bus_wdata   = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_err) begin
                        state_d     = ST_ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = ST_CW;
                        bus_start = 1'b1;
                        op_d      = cmd_op;
                        sel_d     = cmd_sel;
                        count_d   = cmd_count;
                        case (cmd_op)
                            OP_PROGRAM: begin
                                bus_wdata = program_cw(cmd_sel, cmd_rw, cmd_mode, cmd_bcd);
                                fmt_d     = cmd_rw;
                            end
                            OP_LATCH: begin
                                bus_wdata = latch_cw(cmd_sel);
                                fmt_d     = cmd_shadow;
                            end
                            default: begin
                                bus_wdata = readback_cw(cmd_sel);
                                fmt_d     = 2'b01;
                            end
                        endcase
                    end
                end
            end
            ST_CW: begin
                if (bus_done) begin
                    state_d = fmt_q[0] ? ST_LO : ST_HI;
                end
            end
            ST_LO, ST_HI: begin
                bus_addr    = sel_q;
                bus_is_read = (op_q != OP_PROGRAM);
                bus_wdata   = (state_q == ST_LO) ? count_q[7:0] : count_q[15:8];
                bus_start   = bus_gap;
                if (bus_done) begin
                    if (state_q == ST_LO) begin
                        lsb_d = bus_rdata;
                    end
                    if (last_byte) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        shadow_we   = (op_q == OP_PROGRAM);
                        if (op_q != OP_PROGRAM) begin
                            rsp_data_d = {(state_q == ST_HI) ? bus_rdata : 8'h00,
                                          (state_q == ST_LO) ? bus_rdata
                                                             : (fmt_q[0] ? lsb_q : 8'h00)};
                        end
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end
            ST_RESP, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_PROGRAM;
            sel_q       <= 2'b00;
            fmt_q       <= 2'b00;
            count_q     <= 16'h0000;
            lsb_q       <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sel_q       <= sel_d;
            fmt_q       <= fmt_d;
            count_q     <= count_d;
            lsb_q       <= lsb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                shadow_q[i] <= 2'b00;
            end else if (shadow_we && (sel_q == 2'(i))) begin
                shadow_q[i] <= fmt_q;
            end
        end
    end

    pit_bus_cycle #(
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .HOLD_CYC   (HOLD_CYC)
    ) u_bus (
        .clk     (clk),
        .rst     (rst),
        .start   (bus_start),
        .is_read (bus_is_read),
        .addr    (bus_addr),
        .wdata   (bus_wdata),
        .done    (bus_done),
        .gap     (bus_gap),
        .rdata   (bus_rdata),
        .cs_n    (cs_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .a       (a),
        .d_out   (d_out),
        .d_oe    (d_oe),
        .d_in    (d_in)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule
